uart_prog_loader: RTL
=====================

Name: uart_prog_loader

Overview:
- Sits in the user project directly downstream of the serial program stream driven onto mprj_io[5].
- Receives 8N1 UART bytes and packs them little-endian into 32-bit words.
- Writes each word to consecutive instruction-memory addresses.
- Holds the core in reset until a terminator word arrives, then releases it and flags completion.

Parameters:
- CLKS_PER_BIT, 87: clock cycles per UART bit; minimum 4.
- ADDR_W, 10: instruction-memory word-address width.
- END_WORD, 32'h0000_0FFF: terminator word; it is never written to memory.

Ports:
- wb_clk_i  input  1  system clock
- wb_rst_i  input  1  asynchronous, active-high reset
- rx_i  input  1  UART serial input; idle high
- imem_we_o  output  1  instruction-memory write strobe; one-cycle pulse
- imem_addr_o  output  ADDR_W  word address for the write
- imem_wdata_o  output  32  write data
- prog_done_o  output  1  sticky; terminator received
- core_rst_o  output  1  core reset hold; equals ~prog_done_o
- frame_err_o  output  1  sticky; a stop bit was sampled low
- word_count_o  output  ADDR_W+1  number of words written

Behaviour:
- Reset:
  - wb_rst_i is asynchronous and active-high; it clears every register.
  - Reset values: imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, prog_done_o=0, core_rst_o=1, frame_err_o=0, word_count_o=0.
  - Synchronizer flops reset to 1. Any partial word is discarded.
- Input sync: rx_i passes through a 2-FF synchronizer; all logic uses the second stage (rx_s).
- RX FSM states: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: on rx_s==0, clear the bit-period counter and go to START.
  - START: wait CLKS_PER_BIT/2 cycles (floor). If rx_s==1, treat as a glitch and return to IDLE. Otherwise go to DATA.
  - DATA: sample rx_s every CLKS_PER_BIT cycles, 8 samples, LSB first.
  - STOP: sample once after CLKS_PER_BIT cycles.
    - rx_s==1: pulse byte_valid (internal) for one cycle.
    - rx_s==0: set frame_err_o, drop the byte, and reset the byte counter to 0 (word realign).
  - CLEANUP: one cycle, then IDLE.
- Word assembly:
  - A 2-bit byte counter places byte k into word[8k+7:8k].
  - On the 4th byte_valid the assembled word is checked against END_WORD.
  - Word equals END_WORD: prog_done_o goes 1 the next cycle; no write occurs.
  - Otherwise, the next cycle: imem_we_o=1, imem_wdata_o=word, imem_addr_o=current address.
  - On the cycle after the write pulse, the address increments and word_count_o increments.
  - Latency from stop-bit sample of byte 3 to imem_we_o is 1 cycle; there is no backpressure.
- Address wrap: after address 2^ADDR_W-1 the address wraps to 0.
  - word_count_o keeps counting (width ADDR_W+1) and saturates at all-ones.
- After prog_done_o=1:
  - RX FSM keeps running but byte_valid is ignored.
  - No further writes occur; the state is held until wb_rst_i.
- imem_wdata_o and imem_addr_o hold their last values between pulses.
- Simultaneous events: byte_valid and the write pulse cannot coincide, because byte spacing is at least 10*CLKS_PER_BIT cycles.
- frame_err_o is sticky until reset and does not block further reception.

Test Plan:
- Reset then idle (CLKS_PER_BIT=4): hold rx_i=1 for 200 cycles -> no imem_we_o; core_rst_o=1; all other outputs 0.
- Send bytes 0x13,0x05,0x00,0x00, then 0xFF,0x0F,0x00,0x00:
  - one write: addr 0, data 32'h0000_0513;
  - then prog_done_o=1, core_rst_o=0, word_count_o=1.
- Send 3 words 0x11223344, 0xAABBCCDD, 0x00000001, then terminator:
  - writes to addr 0,1,2 with the correct data, each a single-cycle pulse;
  - word_count_o=3.
- Glitch and framing:
  - A 1-cycle low pulse on rx_i gives no byte.
  - A byte sent with stop bit=0 sets frame_err_o=1, drops the byte and realigns.
  - The next 4 valid bytes form one correct write.
- ADDR_W=2: send 5 words -> addresses 0,1,2,3,0 and word_count_o=5.
- Reset mid-operation:
  - Assert wb_rst_i asynchronously after 2 bytes of a word; all outputs return to reset values.
  - The next 4 bytes are written at addr 0.
  - Bytes sent after prog_done_o cause no writes.

Source files
------------

// File: rtl/uart_prog_loader.sv
// Serial program loader: receives 8N1 bytes, packs them little-endian into words and
// writes them to instruction memory, holding the core in reset until the terminator word.
module uart_prog_loader #(
  parameter int          CLKS_PER_BIT = 87,
  parameter int          ADDR_W       = 10,
  parameter logic [31:0] END_WORD     = 32'h0000_0FFF
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              rx_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              prog_done_o,
  output logic              core_rst_o,
  output logic              frame_err_o,
  output logic [ADDR_W:0]   word_count_o
);

  // state   | meaning
  // IDLE    | line idle, waiting for a falling edge
  // START   | half-bit wait, then confirm start bit is still low
  // DATA    | sample 8 data bits LSB first, one per bit period
  // STOP    | sample the stop bit one bit period later
  // CLEANUP | single settle cycle before returning to IDLE
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP} rx_state_t;

  localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;
  logic             rx_m, rx_s;
  logic             stop_tick, byte_valid, frame_bad;
  logic [1:0]       byte_cnt;
  logic [23:0]      word_buf;
  logic [31:0]      full_word;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      rx_byte <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF_LD;
            state <= S_START;
          end
        end
        S_START: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (rx_s) state <= S_IDLE;
          else begin
            cnt     <= FULL_LD;
            bit_idx <= 3'd7;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            rx_byte <= {rx_s, rx_byte[7:1]};
            cnt     <= FULL_LD;
            if (bit_idx == 3'd0) state <= S_STOP;
            else bit_idx <= bit_idx - 1'b1;
          end
        end
        S_STOP: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else state <= S_CLEANUP;
        end
        S_CLEANUP: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Byte is consumed on the stop-bit sample itself so the write lands one cycle later.
  assign stop_tick  = (state == S_STOP) && (cnt == '0);
  assign byte_valid = stop_tick && rx_s;
  assign frame_bad  = stop_tick && !rx_s;
  assign full_word  = {rx_byte, word_buf};
  assign core_rst_o = ~prog_done_o;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      imem_we_o    <= 1'b0;
      imem_addr_o  <= '0;
      imem_wdata_o <= '0;
      prog_done_o  <= 1'b0;
      frame_err_o  <= 1'b0;
      word_count_o <= '0;
      byte_cnt     <= '0;
      word_buf     <= '0;
    end else begin
      imem_we_o <= 1'b0;
      if (imem_we_o) begin
        imem_addr_o <= imem_addr_o + 1'b1;
        if (word_count_o != '1) word_count_o <= word_count_o + 1'b1;
      end
      if (frame_bad) begin
        frame_err_o <= 1'b1;
        byte_cnt    <= '0;
      end else if (byte_valid && !prog_done_o) begin
        byte_cnt <= byte_cnt + 1'b1;
        case (byte_cnt)
          2'd0: word_buf[7:0]   <= rx_byte;
          2'd1: word_buf[15:8]  <= rx_byte;
          2'd2: word_buf[23:16] <= rx_byte;
          default: begin
            if (full_word == END_WORD) prog_done_o <= 1'b1;
            else begin
              imem_we_o    <= 1'b1;
              imem_wdata_o <= full_word;
            end
          end
        endcase
      end
    end
  end

endmodule
